axis_pkt_checker: RTL and testbench

- Synthesizable AXI-Stream packet sink and checker. It is the receive end for AXIS packet streams that a generator drives through FIFOs and routers.
- Consumes packets carrying a defined byte pattern.
- Checks tkeep framing, packet length bounds, the data pattern and packet sequence.
- Exposes packet/byte/error counters for status registers and for on-board bring-up of FIFO paths.

---
 rtl/axis_pkt_checker_pkg.sv | 19 +
 rtl/axis_int.sv | 28 ++
 rtl/axis_pkt_checker_beat_chk.sv | 42 ++++
 rtl/axis_pkt_checker.sv | 204 ++++++++++++++++++++
 tb/tb_axis_pkt_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_checker_pkg.sv
// Shared types and constants for the AXI-Stream packet checker.
package axis_pkt_checker_pkg;

    typedef enum logic {
        IDLE,
        IN_PKT
    } chk_state_e;

    typedef struct packed {
        logic len;
        logic keep;
        logic data;
        logic seq;
    } chk_err_t;

    // Fibonacci feedback taps 16,14,13,11 expressed as a bit mask over state[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_int.sv
// Minimal AXI-Stream interface; DATA_BYTES sets the tdata/tkeep widths.
interface AXIS_int #(
    parameter int DATA_BYTES = 8
) (
    input logic clk
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    logic [7:0]              tid;
    logic [7:0]              tdest;
    logic [0:0]              tuser;

    modport master (
        input  clk,
        output tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  clk,
        input  tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_pkt_checker_beat_chk.sv
// Combinational per-beat check: byte popcount, tkeep framing and data pattern.
module axis_pkt_checker_beat_chk #(
    parameter int DATA_BYTES = 8,
    parameter int PCNT_W     = $clog2(DATA_BYTES + 1)
) (
    input  logic [8*DATA_BYTES-1:0] tdata,
    input  logic [DATA_BYTES-1:0]   tkeep,
    input  logic                    tlast,
    input  logic [7:0]              exp_byte,
    input  logic                    first,
    output logic [PCNT_W-1:0]       popcount,
    output logic                    keep_err,
    output logic                    data_err,
    output logic [7:0]              next_exp_byte
);
    logic [7:0]            base;
    logic [DATA_BYTES-1:0] keep_inc;

    always_comb begin
        // The first beat re-seeds the pattern from its own byte0 so a sequence
        // slip is reported once rather than as a data error on every byte.
        base     = first ? tdata[7:0] : exp_byte;
        popcount = '0;
        data_err = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            popcount = popcount + PCNT_W'(tkeep[i]);
            if (tkeep[i] && (tdata[8*i +: 8] != (base + 8'(i)))) begin
                data_err = 1'b1;
            end
        end

        keep_inc = tkeep + DATA_BYTES'(1);
        if (tlast) begin
            keep_err = (tkeep == '0) || ((tkeep & keep_inc) != '0);
        end else begin
            keep_err = (tkeep != '1);
        end

        next_exp_byte = base + 8'(DATA_BYTES);
    end

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet sink/checker with packet, byte and error counters.
// Define AXIS_PKT_CHECKER_BACKPRESSURE_EN to throttle tready with an LFSR.
module axis_pkt_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter int          MIN_BLEN      = 64,
    parameter int          MAX_BLEN      = 1500,
    parameter int          CNT_WIDTH     = 32,
    parameter int          ERR_CNT_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    AXIS_int.slave                   axis_in,
    input  logic                     enable,
    input  logic                     clear,
    output logic [CNT_WIDTH-1:0]     pkt_count,
    output logic [CNT_WIDTH-1:0]     byte_count,
    output logic [ERR_CNT_WIDTH-1:0] err_len_count,
    output logic [ERR_CNT_WIDTH-1:0] err_keep_count,
    output logic [ERR_CNT_WIDTH-1:0] err_data_count,
    output logic [ERR_CNT_WIDTH-1:0] err_seq_count,
    output logic                     err_pulse
);
    localparam int DATA_BYTES = $bits(axis_in.tkeep);
    localparam int PCNT_W     = $clog2(DATA_BYTES + 1);
    localparam int LEN_W      = $clog2(MAX_BLEN + 2);
    localparam int SUM_W      = LEN_W + 1;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
        input logic [ERR_CNT_WIDTH-1:0] cnt,
        input logic                     hit
    );
        return (hit && (cnt != '1)) ? cnt + ERR_CNT_WIDTH'(1) : cnt;
    endfunction

    chk_state_e               state_q, state_d;
    chk_err_t                 err_q, err_d, err_beat;
    logic [LEN_W-1:0]         len_q, len_d, len_new;
    logic [SUM_W-1:0]         len_sum;
    logic [7:0]               exp_byte_q, exp_byte_d;
    logic [7:0]               byte0_q, byte0_d, byte0;
    logic [7:0]               exp_seq_q, exp_seq_d;
    logic [CNT_WIDTH-1:0]     pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]     byte_count_q, byte_count_d;
    logic [ERR_CNT_WIDTH-1:0] err_len_q, err_len_d;
    logic [ERR_CNT_WIDTH-1:0] err_keep_q, err_keep_d;
    logic [ERR_CNT_WIDTH-1:0] err_data_q, err_data_d;
    logic [ERR_CNT_WIDTH-1:0] err_seq_q, err_seq_d;
    logic                     err_pulse_q, err_pulse_d;

    logic                     tready;
    logic                     beat_acc;
    logic                     first;
    logic [PCNT_W-1:0]        beat_pcnt;
    logic                     beat_keep_err;
    logic                     beat_data_err;
    logic [7:0]               beat_next_exp;

`ifdef AXIS_PKT_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign tready = enable & ~reset & lfsr_q[0];
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign tready      = enable & ~reset;
`endif

    logic unused_axis;
    assign unused_axis = ^{axis_in.clk, axis_in.tstrb, axis_in.tid, axis_in.tdest, axis_in.tuser};

    assign axis_in.tready = tready;
    assign beat_acc       = axis_in.tvalid & tready;
    assign first          = (state_q == IDLE);

    axis_pkt_checker_beat_chk #(
        .DATA_BYTES (DATA_BYTES),
        .PCNT_W     (PCNT_W)
    ) u_beat_chk (
        .tdata         (axis_in.tdata),
        .tkeep         (axis_in.tkeep),
        .tlast         (axis_in.tlast),
        .exp_byte      (exp_byte_q),
        .first         (first),
        .popcount      (beat_pcnt),
        .keep_err      (beat_keep_err),
        .data_err      (beat_data_err),
        .next_exp_byte (beat_next_exp)
    );

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        len_d        = len_q;
        exp_byte_d   = exp_byte_q;
        byte0_d      = byte0_q;
        exp_seq_d    = exp_seq_q;
        pkt_count_d  = pkt_count_q;
        byte_count_d = byte_count_q;
        err_len_d    = err_len_q;
        err_keep_d   = err_keep_q;
        err_data_d   = err_data_q;
        err_seq_d    = err_seq_q;
        err_pulse_d  = 1'b0;

        // Length saturates one past MTU so oversize packets still flag without wrapping
        len_sum = (first ? SUM_W'(0) : {1'b0, len_q}) + SUM_W'(beat_pcnt);
        len_new = (len_sum > SUM_W'(MAX_BLEN + 1)) ? LEN_W'(MAX_BLEN + 1) : len_sum[LEN_W-1:0];
        byte0   = first ? axis_in.tdata[7:0] : byte0_q;

        err_beat.seq  = first ? (byte0 != exp_seq_q) : err_q.seq;
        err_beat.keep = (!first && err_q.keep) || beat_keep_err;
        err_beat.data = (!first && err_q.data) || beat_data_err;
        err_beat.len  = (len_new < LEN_W'(MIN_BLEN)) || (len_new > LEN_W'(MAX_BLEN));

        if (beat_acc) begin
            if (axis_in.tlast) begin
                state_d      = IDLE;
                err_d        = '0;
                exp_seq_d    = byte0 + 8'd1;
                pkt_count_d  = pkt_count_q + CNT_WIDTH'(1);
                byte_count_d = byte_count_q + CNT_WIDTH'(len_new);
                err_len_d    = sat_inc(err_len_q, err_beat.len);
                err_keep_d   = sat_inc(err_keep_q, err_beat.keep);
                err_data_d   = sat_inc(err_data_q, err_beat.data);
                err_seq_d    = sat_inc(err_seq_q, err_beat.seq);
                err_pulse_d  = |err_beat;
            end else begin
                state_d      = IN_PKT;
                err_d        = err_beat;
                err_d.len    = 1'b0;
                len_d        = len_new;
                exp_byte_d   = beat_next_exp;
                byte0_d      = byte0;
            end
        end

        // clear overrides a coincident finalize; the pulse above is kept
        if (clear) begin
            exp_seq_d    = '0;
            pkt_count_d  = '0;
            byte_count_d = '0;
            err_len_d    = '0;
            err_keep_d   = '0;
            err_data_d   = '0;
            err_seq_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            err_q        <= '0;
            exp_seq_q    <= '0;
            pkt_count_q  <= '0;
            byte_count_q <= '0;
            err_len_q    <= '0;
            err_keep_q   <= '0;
            err_data_q   <= '0;
            err_seq_q    <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            exp_seq_q    <= exp_seq_d;
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
            err_len_q    <= err_len_d;
            err_keep_q   <= err_keep_d;
            err_data_q   <= err_data_d;
            err_seq_q    <= err_seq_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    // Per-packet datapath is re-seeded on every first beat, so it needs no reset
    always_ff @(posedge clk) begin
        len_q      <= len_d;
        exp_byte_q <= exp_byte_d;
        byte0_q    <= byte0_d;
    end

    assign pkt_count      = pkt_count_q;
    assign byte_count     = byte_count_q;
    assign err_len_count  = err_len_q;
    assign err_keep_count = err_keep_q;
    assign err_data_count = err_data_q;
    assign err_seq_count  = err_seq_q;
    assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed, table-driven bench for axis_pkt_checker with 8-byte beats.
module tb_axis_pkt_checker;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
    logic [15:0] err_len_count;
    logic [15:0] err_keep_count;
    logic [15:0] err_data_count;
    logic [15:0] err_seq_count;
    logic        err_pulse;

    always #5 clk = ~clk;

    AXIS_int #(.DATA_BYTES(DB)) axis_if (.clk(clk));

    axis_pkt_checker #(
        .MIN_BLEN      (64),
        .MAX_BLEN      (1500),
        .CNT_WIDTH     (32),
        .ERR_CNT_WIDTH (16),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .axis_in        (axis_if),
        .enable         (enable),
        .clear          (clear),
        .pkt_count      (pkt_count),
        .byte_count     (byte_count),
        .err_len_count  (err_len_count),
        .err_keep_count (err_keep_count),
        .err_data_count (err_data_count),
        .err_seq_count  (err_seq_count),
        .err_pulse      (err_pulse)
    );

    typedef struct {
        logic [7:0] seq;
        int         len;
        logic [7:0] last_keep;
        int         bad_beat;
        int         corrupt_k;
        int         e_len;
        int         e_keep;
        int         e_data;
        int         e_seq;
        int         e_bytes;
    } vec_t;

    vec_t vecs[13];

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int m_pkt = 0, m_bytes = 0, m_len = 0, m_keep = 0, m_data = 0, m_seq = 0;

    always @(negedge clk) begin
        if (err_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_count"},  int'(pkt_count),      m_pkt);
        check({tag, "_byte_count"}, int'(byte_count),     m_bytes);
        check({tag, "_err_len"},    int'(err_len_count),  m_len);
        check({tag, "_err_keep"},   int'(err_keep_count), m_keep);
        check({tag, "_err_data"},   int'(err_data_count), m_data);
        check({tag, "_err_seq"},    int'(err_seq_count),  m_seq);
    endtask

    task automatic zero_model();
        m_pkt = 0; m_bytes = 0; m_len = 0; m_keep = 0; m_data = 0; m_seq = 0;
    endtask

    task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic c);
        int waited;
        @(negedge clk);
        axis_if.tdata  = d;
        axis_if.tkeep  = k;
        axis_if.tlast  = l;
        axis_if.tvalid = 1'b1;
        clear          = c;
        #1;
        waited = 0;
        while (!axis_if.tready && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!axis_if.tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: tready stayed 0, required 1");
        end
        @(posedge clk);
    endtask

    task automatic send_pkt(input vec_t v, input int hold_beat, input logic clr_last);
        int         nb;
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  byt;
        int          kk;
        int          rem;
        nb = (v.len + DB - 1) / DB;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < DB; i++) begin
                kk  = b * DB + i;
                byt = v.seq + 8'(kk);
                if (kk == v.corrupt_k) byt = ~byt;
                d[8*i +: 8] = byt;
            end
            rem = v.len - b * DB;
            if (b == nb - 1) k = (v.last_keep != 8'h00) ? v.last_keep : 8'((1 << rem) - 1);
            else             k = (b == v.bad_beat) ? 8'h7F : 8'hFF;
            if (b == hold_beat) begin
                @(negedge clk);
                axis_if.tvalid = 1'b0;
                enable         = 1'b0;
                #1;
                check("tready_enable_low", int'(axis_if.tready), 0);
                repeat (3) @(negedge clk);
                enable = 1'b1;
            end
            put_beat(d, k, (b == nb - 1), clr_last && (b == nb - 1));
        end
        @(negedge clk);
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        clear          = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int hold_beat, input string tag);
        int p0;
        int any;
        p0  = pulse_cnt;
        send_pkt(v, hold_beat, 1'b0);
        any = (v.e_len | v.e_keep | v.e_data | v.e_seq) != 0 ? 1 : 0;
        m_pkt++;
        m_bytes += v.e_bytes;
        m_len   += v.e_len;
        m_keep  += v.e_keep;
        m_data  += v.e_data;
        m_seq   += v.e_seq;
        check({tag, "_pulse"}, pulse_cnt - p0, any);
        check_counters(tag);
    endtask

    initial begin
        vec_t v;
        int   p0;
        logic [63:0] d;

        //          seq    len   lkeep  bad  crpt len keep data seq bytes
        vecs[0]  = '{8'd0,   64,   8'h00, -1,  -1, 0, 0, 0, 0,   64};
        vecs[1]  = '{8'd1,   63,   8'h00, -1,  -1, 1, 0, 0, 0,   63};
        vecs[2]  = '{8'd2,   1500, 8'h00, -1,  -1, 0, 0, 0, 0, 1500};
        vecs[3]  = '{8'd3,   1501, 8'h00, -1,  -1, 1, 0, 0, 0, 1501};
        vecs[4]  = '{8'd4,   100,  8'h00,  3,  -1, 0, 1, 0, 0,   99};
        vecs[5]  = '{8'd5,   72,   8'h05, -1,  -1, 0, 1, 0, 0,   66};
        vecs[6]  = '{8'd7,   64,   8'h00, -1,  -1, 0, 0, 0, 1,   64};
        vecs[7]  = '{8'd8,   200,  8'h00, -1, 100, 0, 0, 1, 0,  200};
        vecs[8]  = '{8'd9,   65,   8'h00, -1,  -1, 0, 0, 0, 0,   65};
        vecs[9]  = '{8'd10,  1,    8'h00, -1,  -1, 1, 0, 0, 0,    1};
        vecs[10] = '{8'd11,  8,    8'h00, -1,  -1, 1, 0, 0, 0,    8};
        vecs[11] = '{8'd255, 64,   8'h00, -1,  -1, 0, 0, 0, 1,   64};
        vecs[12] = '{8'd0,   70,   8'h00, -1,  -1, 0, 0, 0, 0,   70};

        reset          = 1'b1;
        enable         = 1'b1;
        clear          = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tdata  = '0;
        axis_if.tkeep  = '0;
        axis_if.tstrb  = '0;
        axis_if.tlast  = 1'b0;
        axis_if.tid    = '0;
        axis_if.tdest  = '0;
        axis_if.tuser  = '0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_tready", int'(axis_if.tready), 0);
        check("reset_err_pulse", int'(err_pulse), 0);
        check_counters("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], -1, $sformatf("vec%0d", i));
        end

        // enable dropped for several cycles in the middle of a clean packet
        v = '{8'd1, 128, 8'h00, -1, -1, 0, 0, 0, 0, 128};
        run_vec(v, 5, "hold");

        // clear on the finalize beat of a packet carrying a sequence error
        v  = '{8'd50, 64, 8'h00, -1, -1, 0, 0, 0, 1, 64};
        p0 = pulse_cnt;
        send_pkt(v, -1, 1'b1);
        check("clrfin_pulse", pulse_cnt - p0, 1);
        zero_model();
        check_counters("clrfin");

        v = '{8'd0, 64, 8'h00, -1, -1, 0, 0, 0, 0, 64};
        run_vec(v, -1, "postclr");

        // reset two beats into a packet abandons it
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DB; i++) d[8*i +: 8] = 8'(1 + b * DB + i);
            put_beat(d, 8'hFF, 1'b0, 1'b0);
        end
        @(negedge clk);
        axis_if.tvalid = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        zero_model();
        check_counters("midrst");
        check("midrst_err_pulse", int'(err_pulse), 0);

        v = '{8'd0, 64, 8'h00, -1, -1, 0, 0, 0, 0, 64};
        run_vec(v, -1, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
